// File: rtl/muller_c_pipeline.sv
// Muller C-element micropipeline, clocked model.
// DEPTH C-element control stages, each gating a WIDTH-bit data register.
// MODE 0 = four-phase return-to-zero, MODE 1 = two-phase transition signalling.
// Optional token counter output tokens_out is enabled by defining MULLER_C_STATS_EN.
// Parameter limits: WIDTH >= 1, DEPTH >= 2.

module muller_c_stage #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a,
    input  logic             b,
    input  logic [WIDTH-1:0] d_in,
    output logic             c,
    output logic [WIDTH-1:0] d,
    output logic             cap
);
    logic c_nxt;

    // C-element: follow the inputs when they agree, otherwise hold
    always_comb begin
        c_nxt = c;
        if (a && b)
            c_nxt = 1'b1;
        else if (!a && !b)
            c_nxt = 1'b0;
    end

    // A token is a rising control edge in four-phase, any transition in two-phase
    generate
        if (MODE == 0) begin : g_four
            assign cap = c_nxt & ~c;
        end else begin : g_two
            assign cap = c_nxt ^ c;
        end
    endgenerate

    // Control bit and the data it bundles move on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c <= 1'b0;
            d <= '0;
        end else begin
            c <= c_nxt;
            if (cap)
                d <= d_in;
        end
    end
endmodule

module muller_c_pipeline #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int MODE  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
`ifdef MULLER_C_STATS_EN
    output logic             empty,
    output logic [15:0]      tokens_out
`else
    output logic             empty
`endif
);
    logic [DEPTH-1:0]            c;
    logic [DEPTH-1:0]            a;
    logic [DEPTH-1:0]            b;
    logic [DEPTH-1:0]            cap;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] d_src;

    // Every stage sees only registered neighbours, so a token moves one stage per edge
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign a[i]     = req_in;
            assign d_src[i] = data_in;
        end else begin : g_body
            assign a[i]     = c[i-1];
            assign d_src[i] = d[i-1];
        end

        if (i == DEPTH-1) begin : g_tail
            assign b[i] = ~ack_in;
        end else begin : g_mid
            assign b[i] = ~c[i+1];
        end

        muller_c_stage #(.WIDTH(WIDTH), .MODE(MODE)) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .a       (a[i]),
            .b       (b[i]),
            .d_in    (d_src[i]),
            .c       (c[i]),
            .d       (d[i]),
            .cap     (cap[i])
        );
    end

    assign ack_out  = c[0];
    assign req_out  = c[DEPTH-1];
    assign data_out = d[DEPTH-1];
    // No token inside when every adjacent pair of control bits agrees
    assign empty    = (c == {DEPTH{c[0]}});

`ifdef MULLER_C_STATS_EN
    logic [15:0] tokens_cnt;

    // Count tokens leaving; the last stage's capture strobe is exactly a req_out event
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            tokens_cnt <= 16'd0;
        else if (cap[DEPTH-1])
            tokens_cnt <= tokens_cnt + 16'd1;
    end

    assign tokens_out = tokens_cnt;
`endif
endmodule

// File: doc/muller_c_pipeline.md
Name: muller_c_pipeline

Overview:
- Parametrised, clocked model of a Muller C-element micropipeline: DEPTH C-element control stages, each gating a WIDTH-bit data register.
- Successor to the single-C-element project block; adds data bundling, selectable two-/four-phase protocol and depth/width generalisation.
- Sits between the user IO pins and the async demo logic; every C-element evaluation is sampled on the rising clock edge so the block is formally checkable.

Parameters:
- WIDTH, 4, data bits carried per stage (>=1).
- DEPTH, 4, number of C-element stages (>=2).
- MODE, 0, 0 = four-phase return-to-zero; 1 = two-phase transition signalling.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_in  input  1  upstream request.
- data_in  input  WIDTH  upstream bundled data; stable while req_in is asserted/toggled.
- ack_out  output  1  acknowledge to upstream; equals c[0].
- req_out  output  1  downstream request; equals c[DEPTH-1].
- data_out  output  WIDTH  equals d[DEPTH-1].
- ack_in  input  1  downstream acknowledge.
- empty  output  1  high when c[i]==c[i+1] for all i<DEPTH-1 (no token inside).

Behaviour:
- State: control bits c[0..DEPTH-1]; data registers d[0..DEPTH-1].
- Reset (reset_n low, async): all c=0, all d=0. Hence ack_out=0, req_out=0, data_out=0, empty=1. Reset mid-transfer discards every token, with no partial state.
- Per stage i, a_i = c[i-1] (with a_0 = req_in) and b_i = ~c[i+1] (with b_{DEPTH-1} = ~ack_in).
- C rule, evaluated from current register values, all stages in parallel each edge:
  - a&b -> c[i]<=1
  - ~a&~b -> c[i]<=0
  - otherwise c[i] holds.
- Data capture: d[i] <= (i==0 ? data_in : d[i-1]) on the same edge c[i] changes.
  - MODE 0: capture only on a 0->1 change of c[i].
  - MODE 1: capture on any change of c[i].
  - No capture when c[i] holds.
- Latency: req_in change into an empty pipeline with ack_in idle reaches req_out exactly DEPTH edges later, with the matching data_out valid in that same cycle.
- Each stage's C-element advances at most one stage per edge; no combinational path from req_in to req_out or from ack_in to ack_out.
- Back-pressure: with ack_in frozen, tokens accumulate until alternating stages are full.
  - Four-phase capacity is ceil(DEPTH/2) tokens.
  - ack_out then stops following req_in.
- Simultaneous req_in change and ack_in change: both are evaluated in the same edge independently; no priority.
- Upstream protocol violation (req_in withdrawn before ack_out follows it) is tolerated: the C-element holds, no data is captured.
- empty is a registered-value function, valid from the cycle after reset release.

Optional Feature:
- Macro MULLER_C_STATS_EN.
- Defined: adds output tokens_out [15:0], reset 0.
  - Increments on each edge where req_out rises (MODE 0) or changes (MODE 1).
  - Wraps 16'hFFFF -> 0.
  - Cleared asynchronously by reset_n.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: reset_n low with req_in=1, ack_in=1, data_in=4'hF -> ack_out=0, req_out=0, data_out=0, empty=1; hold 3 cycles with no change.
- Latency, MODE 0, DEPTH 4: release reset; req_in 0->1 with data_in=4'hA, ack_in=0 -> req_out=1 and data_out=4'hA on the 4th edge. Then:
  - ack_in=1 -> req_out stays 1.
  - req_in=0 -> req_out=0 four edges later.
  - ack_in=0 -> empty=1.
- Back-pressure, MODE 0, DEPTH 4: ack_in held 0; offer tokens 1,2,3 full four-phase each -> exactly 2 accepted (ack_out stalls on the 3rd). Release ack_in handshakes -> data_out yields 1 then 2, in order, no duplication.
- Two-phase, MODE 1: toggle req_in 3 times with data 5,6,7; ack_in mirrors req_out one cycle later -> req_out toggles 3 times, data_out sequence 5,6,7.
- Mid-operation reset: inject a token, assert reset_n low at edge 2 -> immediate all-zero outputs; after release, a fresh token 4'h3 arrives after exactly DEPTH edges.
- With MULLER_C_STATS_EN: 5 four-phase transfers -> tokens_out=5. Preloading the counter via force to 16'hFFFF plus one transfer -> tokens_out=0.
